lu_compare_driver: RTL and testbench
====================================

// Module: lu_compare_driver
// PURPOSE
// - Initiator for the 6-bit equality/difference compare logic unit: accepts queued compare
//   requests (a, b, select), drives them onto the unit's operand bus, samples its 1-bit result.
// - Returns each result over a valid/ready response channel in request order.
// - Keeps running totals; lets a sequential controller or bench sweep the combinational unit.
// PARAMETERS
// - WIDTH       6   operand width; compare covers all WIDTH bits
// - FIFO_DEPTH  4   request buffer entries; power of 2, >=2
// - SETTLE      1   cycles operands are held stable before the result is sampled; >=1
// - CNTW        8   width of total/hit counters
// PORTS
// - clk          in   1      rising-edge clock
// - reset        in   1      asynchronous, active-high reset
// - req_valid    in   1      request present
// - req_ready    out  1      request buffer can accept
// - req_a        in   WIDTH  operand a
// - req_b        in   WIDTH  operand b
// - req_sel      in   1      0 = equality test, 1 = difference test
// - cmp_a        out  WIDTH  operand a to compare unit
// - cmp_b        out  WIDTH  operand b to compare unit
// - cmp_sel      out  1      select to compare unit
// - cmp_result   in   1      compare unit result (combinational from cmp_*)
// - rsp_valid    out  1      response present
// - rsp_ready    in   1      response consumer ready
// - rsp_result   out  1      sampled cmp_result
// - rsp_sel      out  1      select used for this response
// - busy         out  1      FSM not IDLE or buffer non-empty
// - total_cnt    out  CNTW   responses sampled
// - hit_cnt      out  CNTW   sampled results equal to 1
// - err_flag     out  1      self-check mismatch (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async): FSM=IDLE, buffer empty, all outputs 0 except req_ready=1; counters 0.
// - Buffer: push on req_valid&&req_ready; req_ready = !full from registered count, no bypass.
//   Push and pop in same cycle both take effect; count unchanged.
// - FSM IDLE: buffer non-empty -> pop head into operand regs, go DRIVE.
// - DRIVE: cmp_a/cmp_b/cmp_sel driven from operand regs; hold SETTLE cycles, then SAMPLE.
// - SAMPLE (1 cycle): rsp_result<=cmp_result, rsp_sel<=op sel; total_cnt++, hit_cnt++ if 1;
//   go RESP.
// - RESP: rsp_valid=1, rsp_result/rsp_sel stable until rsp_valid&&rsp_ready; then IDLE.
// - Latency: request accepted at edge t into empty idle block -> rsp_valid high after edge
//   t+SETTLE+2. Back-to-back throughput: one result per SETTLE+3 cycles with rsp_ready=1.
// - cmp_* hold last driven values in IDLE/RESP (no glitching to 0).
// - Capacity: FIFO_DEPTH buffered + 1 in flight; with rsp_ready=0 exactly FIFO_DEPTH+1 accepted.
// - Counters saturate at all-ones; no wrap. Buffer pointers wrap modulo FIFO_DEPTH.
// - Reset mid-operation: in-flight and buffered requests discarded, rsp_valid drops immediately.
// CONFIGURATION
// - LU_DRV_SELFCHECK_EN defined: in SAMPLE compute expected = sel ? (a!=b) : (a==b);
//   cmp_result != expected sets err_flag; sticky until reset.
// - Not defined: no checker logic; err_flag tied 0.
// TESTING
// - Reset: all outputs 0, req_ready=1, busy=0; assert reset in RESP -> rsp_valid=0 same cycle.
// - a=b=6'b000101 sel=0, accept at edge t -> rsp_valid after edge t+3 (SETTLE=1), result=1,
//   total=1, hit=1.
// - a=6'b001010 b=6'b000101 sel=1 -> result=1; then a=b=6'b001010 sel=1 -> result=0, hit unchanged.
// - rsp_ready=0, push 6 requests back-to-back -> 5 accepted, req_ready=0 on 6th; release ->
//   5 responses in order.
// - Counter saturation: preload CNTW=2, 5 hits -> hit_cnt=total_cnt=3, stays 3.
// - SELFCHECK_EN, cmp_result forced 0, a=b sel=0 -> err_flag=1 after SAMPLE, held; without
//   macro err_flag=0.

Source files
------------

// File: rtl/lu_compare_driver.sv
// Request-buffered initiator for a combinational compare unit: queues (a, b, sel) requests,
// drives the unit, samples its result and returns it in order. Optional: LU_DRV_SELFCHECK_EN.
module lu_compare_driver #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETTLE     = 1,
  parameter int unsigned CNTW       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sel,
  output logic [WIDTH-1:0] cmp_a,
  output logic [WIDTH-1:0] cmp_b,
  output logic             cmp_sel,
  input  logic             cmp_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_result,
  output logic             rsp_sel,
  output logic             busy,
  output logic [CNTW-1:0]  total_cnt,
  output logic [CNTW-1:0]  hit_cnt,
  output logic             err_flag
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sel;
  } req_t;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, RESP} state_t;

  state_t         state, state_next;
  req_t           mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_next;
  logic [SW-1:0]  settle_cnt, settle_next;
  logic           push, pop, sample;

  assign push = req_valid && req_ready;

  // Next-state and control decode
  always_comb begin
    state_next  = state;
    settle_next = settle_cnt;
    pop         = 1'b0;
    sample      = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop         = 1'b1;
          settle_next = '0;
          state_next  = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_cnt == SW'(SETTLE - 1)) state_next = SAMPLE;
        else                               settle_next = settle_cnt + SW'(1);
      end
      SAMPLE: begin
        sample     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (!push && pop) count_next = count - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      settle_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
    end else begin
      state      <= state_next;
      settle_cnt <= settle_next;
      count      <= count_next;
      req_ready  <= (count_next != CW'(FIFO_DEPTH));
      busy       <= (state_next != IDLE) || (count_next != '0);
      rsp_valid  <= (state_next == RESP);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: req_a, b: req_b, sel: req_sel};
  end

  // Operand registers double as the unit's bus; they hold between transactions
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_a      <= '0;
      cmp_b      <= '0;
      cmp_sel    <= 1'b0;
      rsp_result <= 1'b0;
      rsp_sel    <= 1'b0;
      total_cnt  <= '0;
      hit_cnt    <= '0;
    end else begin
      if (pop) begin
        cmp_a   <= mem[rd_ptr].a;
        cmp_b   <= mem[rd_ptr].b;
        cmp_sel <= mem[rd_ptr].sel;
      end
      if (sample) begin
        rsp_result <= cmp_result;
        rsp_sel    <= cmp_sel;
        if (total_cnt != '1)              total_cnt <= total_cnt + CNTW'(1);
        if (cmp_result && hit_cnt != '1)  hit_cnt   <= hit_cnt + CNTW'(1);
      end
    end
  end

`ifdef LU_DRV_SELFCHECK_EN
  logic expected_c;
  assign expected_c = cmp_sel ? (cmp_a != cmp_b) : (cmp_a == cmp_b);

  // Sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                err_flag <= 1'b0;
    else if (sample && cmp_result != expected_c) err_flag <= 1'b1;
  end
`else
  assign err_flag = 1'b0;
`endif

endmodule

// File: tb/tb_lu_compare_driver.sv
// Bench for lu_compare_driver: a CNTW=8 and a CNTW=2 instance share stimulus and are
// checked against a queue-based reference model with a behavioural compare unit.
module tb_lu_compare_driver;

  localparam int unsigned W = 6;
`ifdef LU_DRV_SELFCHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_sel = 1'b0;
  logic         rsp_ready = 1'b0;
  logic         force_zero = 1'b0;

  logic         d8_req_ready, d8_cmp_sel, d8_cmp_result, d8_rsp_valid, d8_rsp_result;
  logic         d8_rsp_sel, d8_busy, d8_err;
  logic [W-1:0] d8_cmp_a, d8_cmp_b;
  logic [7:0]   d8_total, d8_hit;
  logic         d2_req_ready, d2_cmp_sel, d2_cmp_result, d2_rsp_valid, d2_rsp_result;
  logic         d2_rsp_sel, d2_busy, d2_err;
  logic [W-1:0] d2_cmp_a, d2_cmp_b;
  logic [1:0]   d2_total, d2_hit;

  int n_cmp = 0;
  int n_err = 0;
  int model_total = 0;
  int model_hit = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // Behavioural compare unit, with a stuck-at-0 override for the self-check scenario
  assign d8_cmp_result = force_zero ? 1'b0 : (d8_cmp_sel ? (d8_cmp_a != d8_cmp_b) : (d8_cmp_a == d8_cmp_b));
  assign d2_cmp_result = force_zero ? 1'b0 : (d2_cmp_sel ? (d2_cmp_a != d2_cmp_b) : (d2_cmp_a == d2_cmp_b));

  lu_compare_driver #(.WIDTH(W), .FIFO_DEPTH(4), .SETTLE(1), .CNTW(8)) dut8 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d8_req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .cmp_a(d8_cmp_a), .cmp_b(d8_cmp_b), .cmp_sel(d8_cmp_sel), .cmp_result(d8_cmp_result),
    .rsp_valid(d8_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(d8_rsp_result),
    .rsp_sel(d8_rsp_sel), .busy(d8_busy), .total_cnt(d8_total), .hit_cnt(d8_hit),
    .err_flag(d8_err));

  lu_compare_driver #(.WIDTH(W), .FIFO_DEPTH(4), .SETTLE(1), .CNTW(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(d2_req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .cmp_a(d2_cmp_a), .cmp_b(d2_cmp_b), .cmp_sel(d2_cmp_sel), .cmp_result(d2_cmp_result),
    .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(d2_rsp_result),
    .rsp_sel(d2_rsp_sel), .busy(d2_busy), .total_cnt(d2_total), .hit_cnt(d2_hit),
    .err_flag(d2_err));

  function automatic logic ref_result(input exp_t e);
    return e.sel ? (e.a != e.b) : (e.a == e.b);
  endfunction

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic apply_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; force_zero = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    model_total = 0; model_hit = 0;
    exp_q.delete();
    @(negedge clk);
  endtask

  // One transaction with rsp_ready asserted once the response shows; no checking here
  task automatic do_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic r, output logic rs, output int lat);
    int guard = 0;
    while (!d8_req_ready && guard < 40) begin @(negedge clk); guard++; end
    req_a = a; req_b = b; req_sel = s; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!d8_rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    r = d8_rsp_result; rs = d8_rsp_sel;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (d8_rsp_valid !== 1'b0 || d2_rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b/%b exp 0", d8_rsp_valid, d2_rsp_valid); end
    n_cmp++; if (d8_req_ready !== 1'b1 || d2_req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b/%b exp 1", d8_req_ready, d2_req_ready); end
    n_cmp++; if (d8_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b exp 0", d8_busy); end
    n_cmp++; if (d8_total !== 8'd0 || d8_hit !== 8'd0) begin n_err++; $display("FAIL reset_counters: got %0d/%0d exp 0/0", d8_total, d8_hit); end
    n_cmp++; if (d8_cmp_a !== '0 || d8_cmp_b !== '0 || d8_cmp_sel !== 1'b0 || d8_rsp_result !== 1'b0 || d8_rsp_sel !== 1'b0)
      begin n_err++; $display("FAIL reset_datapath: got a=%h b=%h sel=%b res=%b rsel=%b exp all 0", d8_cmp_a, d8_cmp_b, d8_cmp_sel, d8_rsp_result, d8_rsp_sel); end
    n_cmp++; if (d8_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b exp 0", d8_err); end
    apply_reset();
  endtask

  task automatic test_latency();
    logic r, rs; int lat;
    do_one(6'b000101, 6'b000101, 1'b0, r, rs, lat);
    model_total++; model_hit++;
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL latency: got %0d exp 3", lat); end
    n_cmp++; if (r !== 1'b1 || rs !== 1'b0) begin n_err++; $display("FAIL lat_result: got res=%b sel=%b exp 1/0", r, rs); end
    n_cmp++; if (d8_total !== 8'd1 || d8_hit !== 8'd1) begin n_err++; $display("FAIL lat_counters: got %0d/%0d exp 1/1", d8_total, d8_hit); end
    n_cmp++; if (d8_rsp_valid !== 1'b0 || d8_busy !== 1'b0) begin n_err++; $display("FAIL lat_idle: got valid=%b busy=%b exp 0/0", d8_rsp_valid, d8_busy); end
    n_cmp++; if (d8_cmp_a !== 6'b000101 || d8_cmp_b !== 6'b000101) begin n_err++; $display("FAIL lat_hold: got %b/%b exp 000101", d8_cmp_a, d8_cmp_b); end
  endtask

  task automatic test_directed();
    logic r, rs; int lat;
    do_one(6'b001010, 6'b000101, 1'b1, r, rs, lat);
    model_total++; model_hit++;
    n_cmp++; if (r !== 1'b1 || rs !== 1'b1) begin n_err++; $display("FAIL diff_ne: got res=%b sel=%b exp 1/1", r, rs); end
    do_one(6'b001010, 6'b001010, 1'b1, r, rs, lat);
    model_total++;
    n_cmp++; if (r !== 1'b0 || rs !== 1'b1) begin n_err++; $display("FAIL diff_eq: got res=%b sel=%b exp 0/1", r, rs); end
    n_cmp++; if (d8_total !== 8'(model_total) || d8_hit !== 8'(model_hit))
      begin n_err++; $display("FAIL dir_counters: got %0d/%0d exp %0d/%0d", d8_total, d8_hit, model_total, model_hit); end
    do_one(6'b110011, 6'b110010, 1'b0, r, rs, lat);
    model_total++;
    n_cmp++; if (r !== 1'b0 || rs !== 1'b0) begin n_err++; $display("FAIL eq_ne: got res=%b sel=%b exp 0/0", r, rs); end
  endtask

  task automatic test_capacity();
    int acc = 0, got = 0, cyc = 0;
    exp_t e;
    logic er;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_a = 6'(i * 7 + 1); req_b = 6'(i * 7 + 1 - (i % 2)); req_sel = 1'((i >> 1) & 1);
      if (i == 5) begin
        n_cmp++; if (d8_req_ready !== 1'b0 || d2_req_ready !== 1'b0) begin n_err++; $display("FAIL cap_full: got %b/%b exp 0", d8_req_ready, d2_req_ready); end
      end
      if (d8_req_ready) begin exp_q.push_back('{a: req_a, b: req_b, sel: req_sel}); acc++; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    n_cmp++; if (acc !== 5) begin n_err++; $display("FAIL cap_accepted: got %0d exp 5", acc); end
    rsp_ready = 1'b1;
    while (got < 5 && cyc < 200) begin
      if (d8_rsp_valid) begin
        e = exp_q.pop_front(); er = ref_result(e);
        model_total++; if (er) model_hit++;
        n_cmp++; if (d8_rsp_result !== er || d8_rsp_sel !== e.sel)
          begin n_err++; $display("FAIL cap_order #%0d: got res=%b sel=%b exp %b/%b", got, d8_rsp_result, d8_rsp_sel, er, e.sel); end
        got++;
      end
      @(negedge clk); cyc++;
    end
    rsp_ready = 1'b0;
    n_cmp++; if (got !== 5) begin n_err++; $display("FAIL cap_drain: got %0d responses exp 5", got); end
  endtask

  task automatic test_back_to_back();
    int pushed = 0, seen = 0, cyc = 0;
    int t[3];
    exp_t e;
    logic er;
    rsp_ready = 1'b1;
    while (seen < 3 && cyc < 100) begin
      if (pushed < 3) begin
        req_valid = 1'b1; req_a = 6'($urandom); req_b = req_a ^ 6'(pushed & 1); req_sel = 1'($urandom);
      end else req_valid = 1'b0;
      if (req_valid && d8_req_ready) begin exp_q.push_back('{a: req_a, b: req_b, sel: req_sel}); pushed++; end
      if (d8_rsp_valid) begin
        t[seen] = cyc;
        e = exp_q.pop_front(); er = ref_result(e);
        model_total++; if (er) model_hit++;
        n_cmp++; if (d8_rsp_result !== er) begin n_err++; $display("FAIL b2b_result #%0d: got %b exp %b", seen, d8_rsp_result, er); end
        seen++;
      end
      @(negedge clk); cyc++;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    n_cmp++;
    if (seen !== 3) begin n_err++; $display("FAIL b2b_timeout: got %0d responses exp 3", seen); end
    else if (t[1] - t[0] !== 4 || t[2] - t[1] !== 4) begin n_err++; $display("FAIL b2b_period: got %0d,%0d exp 4,4", t[1] - t[0], t[2] - t[1]); end
  endtask

  task automatic test_random(input int n);
    int sent = 0, got = 0, cyc = 0;
    logic acc = 1'b0;
    exp_t e;
    logic er;
    while (got < n && cyc < 6000) begin
      if (acc) req_valid = 1'b0;
      acc = 1'b0;
      if (!req_valid && sent < n && $urandom_range(0, 99) < 60) begin
        req_a = 6'($urandom); req_sel = 1'($urandom);
        req_b = ($urandom_range(0, 2) == 0) ? req_a : 6'($urandom);
        req_valid = 1'b1;
      end
      rsp_ready = ($urandom_range(0, 99) < 50);
      if (d2_req_ready !== d8_req_ready || d2_rsp_valid !== d8_rsp_valid) begin
        n_cmp++; n_err++; $display("FAIL rnd_lockstep: d2 ready/valid %b%b d8 %b%b", d2_req_ready, d2_rsp_valid, d8_req_ready, d8_rsp_valid);
      end
      if (req_valid && d8_req_ready) begin exp_q.push_back('{a: req_a, b: req_b, sel: req_sel}); sent++; acc = 1'b1; end
      if (d8_rsp_valid && rsp_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_err++; $display("FAIL rnd_unexpected: response with empty model queue"); end
        else begin
          e = exp_q.pop_front(); er = ref_result(e);
          model_total++; if (er) model_hit++;
          if (d8_rsp_result !== er || d8_rsp_sel !== e.sel || d2_rsp_result !== er || d2_rsp_sel !== e.sel)
            begin n_err++; $display("FAIL rnd_result #%0d: got %b%b/%b%b exp %b%b", got, d8_rsp_result, d8_rsp_sel, d2_rsp_result, d2_rsp_sel, er, e.sel); end
          n_cmp++;
          if (d8_total !== 8'(sat(model_total, 8)) || d8_hit !== 8'(sat(model_hit, 8)) ||
              d2_total !== 2'(sat(model_total, 2)) || d2_hit !== 2'(sat(model_hit, 2)))
            begin n_err++; $display("FAIL rnd_counters #%0d: got %0d/%0d %0d/%0d exp model %0d/%0d", got, d8_total, d8_hit, d2_total, d2_hit, model_total, model_hit); end
        end
        got++;
      end
      @(negedge clk); cyc++;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    n_cmp++; if (got !== n) begin n_err++; $display("FAIL rnd_timeout: got %0d responses exp %0d", got, n); end
    n_cmp++; if (d8_err !== 1'b0) begin n_err++; $display("FAIL rnd_err: got %b exp 0", d8_err); end
  endtask

  task automatic test_saturation();
    logic r, rs; int lat;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      do_one(6'(i), 6'(i), 1'b0, r, rs, lat);
      n_cmp++;
      if (d2_total !== 2'(sat(i, 2)) || d2_hit !== 2'(sat(i, 2)) || d8_total !== 8'(i) || d8_hit !== 8'(i))
        begin n_err++; $display("FAIL sat_hit%0d: got %0d/%0d %0d/%0d exp %0d/%0d %0d/%0d", i, d2_total, d2_hit, d8_total, d8_hit, sat(i, 2), sat(i, 2), i, i); end
    end
  endtask

  task automatic test_selfcheck();
    logic r, rs; int lat;
    apply_reset();
    force_zero = 1'b1;
    do_one(6'b011011, 6'b011011, 1'b0, r, rs, lat);
    force_zero = 1'b0;
    n_cmp++; if (r !== 1'b0) begin n_err++; $display("FAIL sc_forced_result: got %b exp 0", r); end
    n_cmp++; if (d8_err !== EXP_ERR) begin n_err++; $display("FAIL sc_err_set: got %b exp %b", d8_err, EXP_ERR); end
    do_one(6'b000011, 6'b000001, 1'b1, r, rs, lat);
    n_cmp++; if (d8_err !== EXP_ERR || d2_err !== EXP_ERR) begin n_err++; $display("FAIL sc_err_sticky: got %b/%b exp %b", d8_err, d2_err, EXP_ERR); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    logic r, rs; int lat;
    apply_reset();
    req_a = 6'd9; req_b = 6'd9; req_sel = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_a = 6'd3;
    @(negedge clk);
    req_valid = 1'b0;
    while (!d8_rsp_valid && guard < 40) begin @(negedge clk); guard++; end
    n_cmp++; if (d8_rsp_valid !== 1'b1) begin n_err++; $display("FAIL mid_reach_resp: got %b exp 1", d8_rsp_valid); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (d8_rsp_valid !== 1'b0 || d2_rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_valid: got %b/%b exp 0", d8_rsp_valid, d2_rsp_valid); end
    n_cmp++; if (d8_busy !== 1'b0 || d8_req_ready !== 1'b1 || d8_total !== 8'd0)
      begin n_err++; $display("FAIL mid_state: got busy=%b ready=%b total=%0d exp 0/1/0", d8_busy, d8_req_ready, d8_total); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (d8_busy !== 1'b0 || d8_rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_discard: got busy=%b valid=%b exp 0/0", d8_busy, d8_rsp_valid); end
    do_one(6'd12, 6'd40, 1'b1, r, rs, lat);
    n_cmp++; if (r !== 1'b1 || d8_total !== 8'd1 || d8_hit !== 8'd1)
      begin n_err++; $display("FAIL mid_recover: got res=%b total=%0d hit=%0d exp 1/1/1", r, d8_total, d8_hit); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_directed();
    test_capacity();
    test_back_to_back();
    test_random(60);
    test_saturation();
    test_selfcheck();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
